// File: rtl/cpu_pkg.sv
// Shared core types for the fetch front end: widths, the canonical NOP and
// the fetch FSM encoding.
package cpu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    RUN,
    DISCARD
  } fetch_state_e;

  // One buffered instruction; packed so it travels through a 96-bit FIFO.
  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally, and a
// push on full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: nothing is visible until a pointer says so.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (push_i && full_o && !flush_i) |-> pop_i);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited word
// reads, buffers responses with their PCs and flushes on redirect.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d, out_nx;
  logic [OW-1:0]   occ;
  logic [SW-1:0]   live;
  logic            issue, drop, push, pop;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    head, wr_entry;

  // Slots already promised: buffered entries plus responses that will be kept.
  assign live = SW'(occ) + SW'(out_q) - SW'(disc_q);

  assign imem_req  = !reset && !redirect_valid &&
                     (out_q < CW'(MAX_OUT)) && (live < SW'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_gnt;

  assign out_nx = out_q - CW'(imem_rvalid);
  assign drop   = imem_rvalid && (state_q == DISCARD);
  assign push   = imem_rvalid && !drop && !redirect_valid;
  assign pop    = inst_valid && inst_ready;

  assign wr_entry   = '{inst: imem_rdata, pc: resp_pc_q};
  assign inst_valid = !fifo_empty;
  assign inst_data  = fifo_empty ? NOP_INST  : head.inst;
  assign inst_pc    = fifo_empty ? resp_pc_q : head.pc;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occ)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_nx + CW'(issue);
    disc_d     = disc_q;
    state_d    = state_q;
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path.
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      out_d      = out_nx;
      disc_d     = out_nx;
      state_d    = (out_nx != '0) ? DISCARD : RUN;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 64'd4;
      if (push)  resp_pc_d  = resp_pc_q + 64'd4;
      if (drop) begin
        disc_d = disc_q - CW'(1);
        if (disc_q == CW'(1)) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

  a_rvalid_has_out: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (out_q != '0));
  a_out_bound: assert property (@(posedge clk) disable iff (reset)
    (out_q <= CW'(MAX_OUT)) && (disc_q <= out_q));
  a_state_tracks_disc: assert property (@(posedge clk) disable iff (reset)
    (state_q == DISCARD) == (disc_q != '0));
  a_keep_has_slot: assert property (@(posedge clk) disable iff (reset)
    (push && fifo_full) |-> pop);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order imem model with random latency, and a
// reference of the delivered/issued PC streams kept as simple counters.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        w_req, w_valid;
  logic [63:0] w_addr, w_pc;
  logic [31:0] w_data;

  always #5 clk = ~clk;

  fetch_queue #(.RESET_PC(64'h0), .DEPTH(4), .MAX_OUT(4)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  // Lockstep twin starting near the top of the address space.
  fetch_queue #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .DEPTH(4), .MAX_OUT(4)) u_wrap (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(w_valid), .inst_ready(inst_ready), .inst_data(w_data), .inst_pc(w_pc)
  );

  int          n_tests = 0, n_fail = 0, n_pop = 0, cyc = 0;
  int          gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  bit          rv_now, hold_q;
  logic [63:0] hold_addr, exp_pc, exp_fetch;

  function automatic logic [31:0] hash(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC3A5_0F17;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs at the negedge, then let combinational outputs settle.
  task automatic drive(input bit redir, input logic [63:0] rpc);
    rv_now         = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    imem_rvalid    = rv_now;
    imem_rdata     = rv_now ? hash(pend_addr[0]) : 32'h0;
    imem_gnt       = (int'($urandom_range(99, 0)) < gnt_pct);
    inst_ready     = (int'($urandom_range(99, 0)) < rdy_pct);
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  // Check the handshakes that fire at the coming edge and advance the model.
  task automatic commit();
    if (!reset) begin
      if (redirect_valid) chk("req_in_redirect", imem_req, 0);
      if (hold_q && imem_req) chk("addr_stable", imem_addr, hold_addr);
      if (imem_req && imem_gnt) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        exp_fetch = exp_fetch + 64'd4;
      end
      if (inst_valid && inst_ready) begin
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_data", inst_data, hash(exp_pc));
        exp_pc = exp_pc + 64'd4;
        n_pop++;
      end
      hold_q    = imem_req && !imem_gnt;
      hold_addr = imem_addr;
      if (redirect_valid) begin
        exp_pc    = {redirect_pc[63:2], 2'b00};
        exp_fetch = {redirect_pc[63:2], 2'b00};
      end
    end
    if (rv_now) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    drive(1'b0, 64'h0);
    commit();
  endtask

  task automatic do_reset();
    gnt_pct = 0;
    rdy_pct = 0;
    for (int i = 0; i < 60 && pend_addr.size() > 0; i++) step();
    if (pend_addr.size() != 0) chk("drain_timeout", pend_addr.size(), 0);
    reset = 1'b1;
    step();
    drive(1'b0, 64'h0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 32'h0000_0013);
    chk("rst_pc", inst_pc, 64'h0);
    chk("rst_wrap_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("rst_wrap_data", w_data, 32'h0000_0013);
    commit();
    reset     = 1'b0;
    exp_pc    = 64'h0;
    exp_fetch = 64'h0;
    hold_q    = 1'b0;
  endtask

  typedef struct {
    bit          rdy;
    bit          e_req;
    logic [63:0] e_addr;
    logic [63:0] e_waddr;
    bit          e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_wpc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int  n0;
    bit  got;
    logic [63:0] tgt;

    // Latency-1 imem, always granted; rows 5-7 stall the consumer until credit runs out.
    vecs[0] = '{1, 1, 64'h00, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h0, 64'h0};
    vecs[1] = '{1, 1, 64'h04, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 64'h0};
    vecs[2] = '{1, 1, 64'h08, 64'h00, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[3] = '{1, 1, 64'h0C, 64'h04, 1, 64'h4, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[4] = '{1, 1, 64'h10, 64'h08, 1, 64'h8, 64'h0};
    vecs[5] = '{0, 1, 64'h14, 64'h0C, 1, 64'hC, 64'h4};
    vecs[6] = '{0, 1, 64'h18, 64'h10, 1, 64'hC, 64'h4};
    vecs[7] = '{0, 0, 64'h1C, 64'h14, 1, 64'hC, 64'h4};

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    @(negedge clk);
    do_reset();

    gnt_pct = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) begin
      rdy_pct = vecs[i].rdy ? 100 : 0;
      drive(1'b0, 64'h0);
      chk($sformatf("vec%0d_req", i), imem_req, vecs[i].e_req);
      chk($sformatf("vec%0d_wreq", i), w_req, vecs[i].e_req);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_waddr", i), w_addr, vecs[i].e_waddr);
      chk($sformatf("vec%0d_valid", i), inst_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_wvalid", i), w_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i), inst_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d_wpc", i), w_pc, vecs[i].e_wpc);
      end
      commit();
    end

    // Consumer stalled: buffer fills to exactly DEPTH, then drains in order.
    rdy_pct = 0;
    repeat (12) step();
    drive(1'b0, 64'h0);
    chk("stall_req_low", imem_req, 0);
    chk("stall_valid", inst_valid, 1);
    commit();
    gnt_pct = 0; rdy_pct = 100; n0 = n_pop;
    repeat (8) step();
    chk("stall_held_entries", n_pop - n0, 4);
    gnt_pct = 100;
    repeat (12) step();

    // Three requests in flight at latency 5, then a misaligned redirect.
    do_reset();
    lat_min = 5; lat_max = 5; gnt_pct = 100; rdy_pct = 100;
    repeat (3) step();
    gnt_pct = 0;
    drive(1'b1, 64'h1002);
    commit();
    gnt_pct = 100;
    drive(1'b0, 64'h0);
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 64'h1000);
    commit();
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      drive(1'b0, 64'h0);
      if (inst_valid && inst_ready) begin
        chk("redir_first_pc", inst_pc, 64'h1000);
        got = 1;
      end
      commit();
    end
    if (!got) chk("redir_first_timeout", 0, 1);

    // Redirect landing on a cycle that both pops the head and returns a response.
    do_reset();
    lat_min = 3; lat_max = 3; gnt_pct = 100; rdy_pct = 100;
    repeat (8) step();
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (pend_addr.size() > 0 && pend_due[0] <= cyc && inst_valid) begin
        drive(1'b1, 64'h2000);
        commit();
        got = 1;
      end else step();
    end
    if (!got) chk("coinc_timeout", 0, 1);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      drive(1'b0, 64'h0);
      if (inst_valid && inst_ready) begin
        chk("coinc_first_pc", inst_pc, 64'h2000);
        got = 1;
      end
      commit();
    end
    if (!got) chk("coinc_first_timeout", 0, 1);

    // Random grant, latency, back-pressure and redirects (some near the wrap point).
    do_reset();
    lat_min = 1; lat_max = 6; gnt_pct = 60; rdy_pct = 70; n0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) < 4) begin
        tgt = {$urandom, $urandom};
        if ($urandom_range(3, 0) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFE0 | 64'(tgt[4:0]);
        drive(1'b1, tgt);
      end else drive(1'b0, 64'h0);
      commit();
    end
    chk("rand_progress", (n_pop - n0) > 200, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
